// File: rtl/sift_pkg.sv
// Shared sizing, state encoding and row widths for the SIFT pyramid stages.
package sift_pkg;
    localparam int COLS   = 640;
    localparam int PIX_W  = 8;
    localparam int ROWS   = 480;
    localparam int AW     = 9;
    localparam int DOG_W  = PIX_W + 1;
    localparam int ROW_W  = COLS * PIX_W;
    localparam int DROW_W = COLS * DOG_W;

    localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;
endpackage

// File: rtl/dog_subtract_if.sv
// Controller handshake plus blur-SRAM read and DoG-SRAM write buses of the DoG stage.
// master = DoG engine side, slave = controller/SRAM side.
interface dog_subtract_if;
    import sift_pkg::*;

    logic              start;
    logic              done;
    logic              busy;
    logic              blur_re;
    logic [AW-1:0]     blur_addr;
    logic [ROW_W-1:0]  blur_dout_0;
    logic [ROW_W-1:0]  blur_dout_1;
    logic [ROW_W-1:0]  blur_dout_2;
    logic [ROW_W-1:0]  blur_dout_3;
    logic              dog_we;
    logic [AW-1:0]     dog_addr;
    logic [DROW_W-1:0] dog_din_0;
    logic [DROW_W-1:0] dog_din_1;
    logic [DROW_W-1:0] dog_din_2;

    modport master (
        input  start, blur_dout_0, blur_dout_1, blur_dout_2, blur_dout_3,
        output done, busy, blur_re, blur_addr, dog_we, dog_addr,
               dog_din_0, dog_din_1, dog_din_2
    );

    modport slave (
        output start, blur_dout_0, blur_dout_1, blur_dout_2, blur_dout_3,
        input  done, busy, blur_re, blur_addr, dog_we, dog_addr,
               dog_din_0, dog_din_1, dog_din_2
    );
endinterface

// File: rtl/dog_row_sub.sv
// Combinational full-row subtractor: diff[i] = hi[i] - lo[i] as signed 9-bit per pixel.
// Zero latency; no flow control.
module dog_row_sub
    import sift_pkg::*;
(
    input  logic [ROW_W-1:0]  hi,
    input  logic [ROW_W-1:0]  lo,
    output logic [DROW_W-1:0] diff
);
    for (genvar i = 0; i < COLS; i++) begin : g_pix
        // Zero-extend both operands so the 9-bit result covers -255..+255 exactly.
        assign diff[i*DOG_W +: DOG_W] = {1'b0, hi[i*PIX_W +: PIX_W]}
                                      - {1'b0, lo[i*PIX_W +: PIX_W]};
    end
endmodule

// File: rtl/dog_subtract.sv
// Streams four blur rows per clock and writes three DoG rows; write for row r lands 2 cycles after read.
// No backpressure: once started, one row per cycle until done.
module dog_subtract
    import sift_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    dog_subtract_if.master bus
);
    state_e            state_q, state_d;
    logic              drain_cnt_q, drain_cnt_d;
    logic              blur_re_q, blur_re_d;
    logic [AW-1:0]     blur_addr_q, blur_addr_d;
    logic              s1_valid_q, s1_valid_d;
    logic [AW-1:0]     s1_addr_q, s1_addr_d;
    logic              dog_we_q, dog_we_d;
    logic [AW-1:0]     dog_addr_q, dog_addr_d;
    logic [DROW_W-1:0] dog_din_0_q, dog_din_0_d;
    logic [DROW_W-1:0] dog_din_1_q, dog_din_1_d;
    logic [DROW_W-1:0] dog_din_2_q, dog_din_2_d;

    logic [DROW_W-1:0] diff_0, diff_1, diff_2;

    dog_row_sub u_sub_0 (.hi(bus.blur_dout_1), .lo(bus.blur_dout_0), .diff(diff_0));
    dog_row_sub u_sub_1 (.hi(bus.blur_dout_2), .lo(bus.blur_dout_1), .diff(diff_1));
    dog_row_sub u_sub_2 (.hi(bus.blur_dout_3), .lo(bus.blur_dout_2), .diff(diff_2));

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        blur_re_d   = blur_re_q;
        blur_addr_d = blur_addr_q;
        // Stage 1 tracks the SRAM read latency; stage 2 captures the subtracted row.
        s1_valid_d  = blur_re_q;
        s1_addr_d   = blur_addr_q;
        dog_we_d    = s1_valid_q;
        dog_addr_d  = s1_valid_q ? s1_addr_q : dog_addr_q;
        dog_din_0_d = s1_valid_q ? diff_0 : dog_din_0_q;
        dog_din_1_d = s1_valid_q ? diff_1 : dog_din_1_q;
        dog_din_2_d = s1_valid_q ? diff_2 : dog_din_2_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d     = ST_RUN;
                    blur_re_d   = 1'b1;
                    blur_addr_d = '0;
                end
            end
            ST_RUN: begin
                if (blur_addr_q == LAST_ROW) begin
                    state_d     = ST_DRAIN;
                    blur_re_d   = 1'b0;
                    drain_cnt_d = 1'b0;
                end else begin
                    blur_addr_d = blur_addr_q + AW'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q) begin
                    state_d = ST_DONE;
                end else begin
                    drain_cnt_d = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            drain_cnt_q <= 1'b0;
            blur_re_q   <= 1'b0;
            blur_addr_q <= '0;
            s1_valid_q  <= 1'b0;
            s1_addr_q   <= '0;
            dog_we_q    <= 1'b0;
            dog_addr_q  <= '0;
            dog_din_0_q <= '0;
            dog_din_1_q <= '0;
            dog_din_2_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            blur_re_q   <= blur_re_d;
            blur_addr_q <= blur_addr_d;
            s1_valid_q  <= s1_valid_d;
            s1_addr_q   <= s1_addr_d;
            dog_we_q    <= dog_we_d;
            dog_addr_q  <= dog_addr_d;
            dog_din_0_q <= dog_din_0_d;
            dog_din_1_q <= dog_din_1_d;
            dog_din_2_q <= dog_din_2_d;
        end
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.blur_re   = blur_re_q;
    assign bus.blur_addr = blur_addr_q;
    assign bus.dog_we    = dog_we_q;
    assign bus.dog_addr  = dog_addr_q;
    assign bus.dog_din_0 = dog_din_0_q;
    assign bus.dog_din_1 = dog_din_1_q;
    assign bus.dog_din_2 = dog_din_2_q;
endmodule

// File: tb/tb_dog_subtract.sv
// Directed bench for dog_subtract: models the four blur SRAMs and checks every DoG write.
module tb_dog_subtract;
    import sift_pkg::*;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   done_cnt = 0;
    int   mode = 0;

    dog_subtract_if bus ();

    dog_subtract dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Blur row contents per scale k, test mode and row r.
    function automatic logic [ROW_W-1:0] blur_row(input int k, input int md, input int r);
        logic [ROW_W-1:0] v;
        v = '0;
        for (int i = 0; i < COLS; i++) begin
            case (md)
                0: v[i*PIX_W +: PIX_W] = (k == 0) ? 8'd10 : (k == 1) ? 8'd30 : 8'd25;
                1: v[i*PIX_W +: PIX_W] = 8'd77;
                default: v[i*PIX_W +: PIX_W] = 8'd0;
            endcase
        end
        if (md == 1) begin
            v[0 +: PIX_W]              = (k % 2 == 0) ? 8'd255 : 8'd0;
            v[(COLS-1)*PIX_W +: PIX_W] = (k % 2 == 0) ? 8'd0 : 8'd255;
        end
        if (md == 2) begin
            v[0 +: PIX_W] = (k == 0) ? 8'(r % 128) : 8'(2 * (r % 128));
        end
        return v;
    endfunction

    // Hand-derived expected DoG rows.
    function automatic logic [DROW_W-1:0] exp_dog(input int k, input int md, input int r);
        logic [DROW_W-1:0] v;
        v = '0;
        if (md == 0) begin
            for (int i = 0; i < COLS; i++)
                v[i*DOG_W +: DOG_W] = (k == 0) ? 9'h014 : (k == 1) ? 9'h1FB : 9'h000;
        end else if (md == 1) begin
            v[0 +: DOG_W]              = (k == 1) ? 9'h0FF : 9'h101;
            v[(COLS-1)*DOG_W +: DOG_W] = (k == 1) ? 9'h101 : 9'h0FF;
        end else if (k == 0) begin
            v[0 +: DOG_W] = 9'(r % 128);
        end
        return v;
    endfunction

    // Blur SRAM model: data valid one cycle after the address.
    always @(posedge clk) begin
        if (bus.blur_re) begin
            bus.blur_dout_0 <= blur_row(0, mode, int'(bus.blur_addr));
            bus.blur_dout_1 <= blur_row(1, mode, int'(bus.blur_addr));
            bus.blur_dout_2 <= blur_row(2, mode, int'(bus.blur_addr));
            bus.blur_dout_3 <= blur_row(3, mode, int'(bus.blur_addr));
        end
    end

    always @(posedge clk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_row(input string tag, input logic [DROW_W-1:0] obs, input logic [DROW_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s addr=%0d observed_lo=%h observed_hi=%h expected_lo=%h expected_hi=%h",
                   tag, bus.dog_addr, obs[35:0], obs[DROW_W-1 -: 36], exp[35:0], exp[DROW_W-1 -: 36]);
        end
    endtask

    // Starts at an IDLE negedge; returns at the negedge of the first IDLE cycle after done.
    task automatic run_pass(input int md, input bit hold);
        int d0;
        mode = md;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) bus.start = 1'b0;
        d0 = done_cnt;
        chk("first_re", 32'(bus.blur_re), 32'd1);
        chk("first_addr", 32'(bus.blur_addr), 32'd0);
        chk("busy_run", 32'(bus.busy), 32'd1);
        @(negedge clk);
        chk("we_before_first", 32'(bus.dog_we), 32'd0);
        for (int i = 0; i < ROWS; i++) begin
            @(negedge clk);
            chk("we", 32'(bus.dog_we), 32'd1);
            chk("waddr", 32'(bus.dog_addr), 32'(i));
            chk("done_early", 32'(bus.done), 32'd0);
            chk("blur_addr_max", 32'(bus.blur_addr <= LAST_ROW), 32'd1);
            chk_row("din0", bus.dog_din_0, exp_dog(0, md, i));
            chk_row("din1", bus.dog_din_1, exp_dog(1, md, i));
            chk_row("din2", bus.dog_din_2, exp_dog(2, md, i));
        end
        @(negedge clk);
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("we_in_done", 32'(bus.dog_we), 32'd0);
        chk("re_in_done", 32'(bus.blur_re), 32'd0);
        @(negedge clk);
        chk("done_after", 32'(bus.done), 32'd0);
        chk("busy_after", 32'(bus.busy), 32'd0);
        chk("done_count", 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        bit found;
        rst_n = 1'b0;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_re", 32'(bus.blur_re), 32'd0);
        chk("rst_we", 32'(bus.dog_we), 32'd0);
        chk("rst_baddr", 32'(bus.blur_addr), 32'd0);
        chk("rst_daddr", 32'(bus.dog_addr), 32'd0);
        chk_row("rst_din0", bus.dog_din_0, '0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_start", 32'(bus.busy), 32'd0);

        run_pass(0, 1'b0);
        run_pass(1, 1'b0);
        run_pass(2, 1'b0);

        // start held high: the DONE-cycle start is ignored, next pass follows from IDLE.
        run_pass(0, 1'b1);
        run_pass(0, 1'b1);
        bus.start = 1'b0;
        @(negedge clk);
        chk("held_stop_busy", 32'(bus.busy), 32'd0);

        // Reset in the middle of a pass.
        mode = 0;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 600 && !found; c++) begin
            if (bus.blur_addr == AW'(200)) found = 1'b1;
            else @(negedge clk);
        end
        chk("reach_row200", 32'(found), 32'd1);
        d0 = done_cnt;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_we", 32'(bus.dog_we), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_done", 32'(bus.done), 32'd0);
        chk("mid_rst_re", 32'(bus.blur_re), 32'd0);
        chk("mid_rst_baddr", 32'(bus.blur_addr), 32'd0);
        chk("mid_rst_daddr", 32'(bus.dog_addr), 32'd0);
        chk_row("mid_rst_din1", bus.dog_din_1, '0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("post_rst_we", 32'(bus.dog_we), 32'd0);
        end
        chk("post_rst_no_done", 32'(done_cnt - d0), 32'd0);
        run_pass(0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
